// File: rtl/seg7_pkg.sv
// Shared types, glyph constants and the 4-bit to 7-segment lookup for the
// multiplexed display driver. Segments are ordered a..g with seg[0]=a, active-low.
package seg7_pkg;

    typedef logic [0:6] seg_t;

    localparam seg_t SEG_0     = 7'b0000001;
    localparam seg_t SEG_1     = 7'b1001111;
    localparam seg_t SEG_2     = 7'b0010010;
    localparam seg_t SEG_3     = 7'b0000110;
    localparam seg_t SEG_4     = 7'b1001100;
    localparam seg_t SEG_5     = 7'b0100100;
    localparam seg_t SEG_6     = 7'b0100000;
    localparam seg_t SEG_7     = 7'b0001111;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0000100;
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_B     = 7'b1100000;
    localparam seg_t SEG_C     = 7'b0110001;
    localparam seg_t SEG_D     = 7'b1000010;
    localparam seg_t SEG_E     = 7'b0110000;
    localparam seg_t SEG_F     = 7'b0111000;
    localparam seg_t SEG_BLANK = 7'b1111111;

    function automatic seg_t digit_to_seg(input logic [3:0] code, input logic hex_mode);
        seg_t glyph;
        case (code)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            // Non-decimal codes only render when the build opts into hex digits.
            4'd10:   glyph = hex_mode ? SEG_A : SEG_BLANK;
            4'd11:   glyph = hex_mode ? SEG_B : SEG_BLANK;
            4'd12:   glyph = hex_mode ? SEG_C : SEG_BLANK;
            4'd13:   glyph = hex_mode ? SEG_D : SEG_BLANK;
            4'd14:   glyph = hex_mode ? SEG_E : SEG_BLANK;
            4'd15:   glyph = hex_mode ? SEG_F : SEG_BLANK;
            default: glyph = SEG_BLANK;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational digit decoder: one 4-bit code to an active-low segment pattern.
module seg7_hex_dec
    import seg7_pkg::*;
#(
    parameter int HEX_MODE = 0
) (
    input  logic [3:0] code,
    output seg_t       seg
);

    assign seg = digit_to_seg(code, (HEX_MODE != 0));

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed common-anode 7-segment driver with per-frame snapshots,
// leading-zero blanking, decimal points and registered pin outputs.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int SCAN_DIV      = 50000,
    parameter int HEX_MODE      = 0,
    parameter int AN_ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      blank_lz,
    output seg_t                      seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_st
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [PW-1:0]           presc_r;
    logic [IW-1:0]           idx_r;
    logic [4*NUM_DIGITS-1:0] snap_r;
    logic [NUM_DIGITS-1:0]   snap_dp_r;
    logic                    snap_blz_r;
    logic                    load_pend_r;

    logic                    tick_s;
    logic                    last_digit_s;
    logic                    take_s;
    logic [3:0]              cur_code_s;
    seg_t                    dec_seg_s;
    logic [NUM_DIGITS-1:0]   blank_mask_s;
    logic [NUM_DIGITS-1:0]   an_on_s;

    assign tick_s       = (presc_r == PW'(SCAN_DIV - 1));
    assign last_digit_s = (idx_r == IW'(NUM_DIGITS - 1));
    assign take_s       = en & (load_pend_r | (tick_s & last_digit_s));
    assign cur_code_s   = snap_r[{idx_r, 2'b00} +: 4];
    assign an_on_s      = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_r;

    seg7_hex_dec #(.HEX_MODE(HEX_MODE)) u_dec (
        .code (cur_code_s),
        .seg  (dec_seg_s)
    );

    // Prescaler and digit index; both freeze while the display is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r <= {PW{1'b0}};
            idx_r   <= {IW{1'b0}};
        end else if (en) begin
            if (tick_s) begin
                presc_r <= {PW{1'b0}};
                idx_r   <= last_digit_s ? {IW{1'b0}} : idx_r + IW'(1);
            end else begin
                presc_r <= presc_r + PW'(1);
            end
        end
    end

    // Frame snapshot: inputs are sampled once per frame so a scan never tears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_r      <= {(4*NUM_DIGITS){1'b0}};
            snap_dp_r   <= {NUM_DIGITS{1'b0}};
            snap_blz_r  <= 1'b0;
            load_pend_r <= 1'b1;
        end else if (take_s) begin
            snap_r      <= value;
            snap_dp_r   <= dp_in;
            snap_blz_r  <= blank_lz;
            load_pend_r <= 1'b0;
        end
    end

    // Leading-zero mask: walk from the top digit down while every digit seen is zero.
    always_comb begin
        logic upper_zero;
        upper_zero   = 1'b1;
        blank_mask_s = {NUM_DIGITS{1'b0}};
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero & (snap_r[4*i +: 4] == 4'd0);
            if (snap_blz_r && (i > 0) && upper_zero) begin
                blank_mask_s[i] = 1'b1;
            end else begin
                blank_mask_s[i] = 1'b0;
            end
        end
    end

    // Pin registers, one cycle behind the index/snapshot they are derived from.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg      <= SEG_BLANK;
            dp       <= 1'b1;
            an       <= AN_OFF;
            frame_st <= 1'b0;
        end else if (!en) begin
            seg      <= SEG_BLANK;
            dp       <= 1'b1;
            an       <= AN_OFF;
            frame_st <= 1'b0;
        end else begin
            seg      <= blank_mask_s[idx_r] ? SEG_BLANK : dec_seg_s;
            dp       <= blank_mask_s[idx_r] ? 1'b1 : ~snap_dp_r[idx_r];
            an       <= (AN_ACTIVE_LOW != 0) ? ~an_on_s : an_on_s;
            frame_st <= take_s;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: a behavioural display model queues the expected
// pins per cycle, a monitor compares two DUT builds (decimal/active-low, hex/active-high).
module tb_seg7_scan;

    localparam int N  = 4;
    localparam int SD = 4;

    typedef struct packed {
        logic [6:0] seg0;
        logic [6:0] seg1;
        logic       dp;
        logic [3:0] an;
        logic       fs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic        blank_lz = 1'b0;
    logic [0:6]  seg0, seg1;
    logic        dp0, dp1, fs0, fs1;
    logic [3:0]  an0, an1;

    int vectors = 0;
    int miscompares = 0;
    exp_t q[$];
    logic [6:0] glyph [16];

    int          m_presc, m_idx;
    logic [15:0] m_snap;
    logic [3:0]  m_dp;
    bit          m_blz, m_lp;

    seg7_scan #(.NUM_DIGITS(N), .SCAN_DIV(SD), .HEX_MODE(0), .AN_ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .en(en), .value(value), .dp_in(dp_in), .blank_lz(blank_lz),
        .seg(seg0), .dp(dp0), .an(an0), .frame_st(fs0));

    seg7_scan #(.NUM_DIGITS(N), .SCAN_DIV(SD), .HEX_MODE(1), .AN_ACTIVE_LOW(0)) dut_h (
        .clk(clk), .rst(rst), .en(en), .value(value), .dp_in(dp_in), .blank_lz(blank_lz),
        .seg(seg1), .dp(dp1), .an(an1), .frame_st(fs1));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [6:0] model_seg(input int code, input bit hex);
        if (code < 10 || hex) return glyph[code];
        return 7'b1111111;
    endfunction

    // One clock of stimulus; the model predicts the pins after the next rising edge.
    task automatic apply(input bit r, input bit e_in, input logic [15:0] v, input logic [3:0] d, input bit b);
        exp_t ex;
        bit take, blank;
        int code;
        @(negedge clk);
        rst = r; en = e_in; value = v; dp_in = d; blank_lz = b;
        ex.seg0 = 7'b1111111; ex.seg1 = 7'b1111111; ex.dp = 1'b1; ex.an = 4'b1111; ex.fs = 1'b0;
        if (r) begin
            m_presc = 0; m_idx = 0; m_snap = 16'h0000; m_dp = 4'h0; m_blz = 1'b0; m_lp = 1'b1;
        end else if (e_in) begin
            take  = m_lp || (m_presc == SD - 1 && m_idx == N - 1);
            code  = int'(m_snap[4*m_idx +: 4]);
            blank = m_blz && m_idx > 0 && ((m_snap >> (4 * m_idx)) == 16'd0);
            ex.seg0 = blank ? 7'b1111111 : model_seg(code, 1'b0);
            ex.seg1 = blank ? 7'b1111111 : model_seg(code, 1'b1);
            ex.dp   = blank ? 1'b1 : ~m_dp[m_idx];
            ex.an   = ~(4'b0001 << m_idx);
            ex.fs   = take;
            if (m_presc == SD - 1) begin
                m_presc = 0;
                m_idx   = (m_idx + 1) % N;
            end else begin
                m_presc = m_presc + 1;
            end
            if (take) begin
                m_snap = v; m_dp = d; m_blz = b; m_lp = 1'b0;
            end
        end
        q.push_back(ex);
        if (r) begin
            #1;
            check("async_rst_seg0", {1'b0, seg0}, 8'h7F);
            check("async_rst_seg1", {1'b0, seg1}, 8'h7F);
            check("async_rst_dp", {6'd0, dp0, dp1}, 8'h03);
            check("async_rst_an", {an0, an1}, 8'hF0);
            check("async_rst_fs", {6'd0, fs0, fs1}, 8'h00);
        end
    endtask

    // Monitor: compare every queued expectation just after the edge it belongs to.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("seg_dec", {1'b0, seg0}, {1'b0, e.seg0});
            check("seg_hex", {1'b0, seg1}, {1'b0, e.seg1});
            check("dp_dec", {7'd0, dp0}, {7'd0, e.dp});
            check("dp_hex", {7'd0, dp1}, {7'd0, e.dp});
            check("an_low", {4'd0, an0}, {4'd0, e.an});
            check("an_high", {4'd0, an1}, {4'd0, ~e.an});
            check("frame_st", {6'd0, fs0, fs1}, {6'd0, e.fs, e.fs});
        end
    end

    initial begin
        logic [15:0] v;
        glyph = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
                  7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                  7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        repeat (2) apply(1'b1, 1'b0, 16'h0000, 4'h0, 1'b0);
        repeat (40) apply(1'b0, 1'b1, 16'h1234, 4'h0, 1'b0);
        apply(1'b1, 1'b1, 16'h1234, 4'h0, 1'b0);
        repeat (36) apply(1'b0, 1'b1, 16'h0050, 4'h0, 1'b1);
        repeat (32) apply(1'b0, 1'b1, 16'h0000, 4'h0, 1'b1);
        repeat (6)  apply(1'b0, 1'b1, 16'h1111, 4'h0, 1'b0);
        repeat (40) apply(1'b0, 1'b1, 16'h2222, 4'h0, 1'b0);
        repeat (36) apply(1'b0, 1'b1, 16'hABCF, 4'b0100, 1'b0);
        repeat (6)  apply(1'b0, 1'b1, 16'h9876, 4'b1001, 1'b0);
        repeat (10) apply(1'b0, 1'b0, 16'h5555, 4'hF, 1'b0);
        repeat (24) apply(1'b0, 1'b1, 16'h5555, 4'hF, 1'b0);
        for (int k = 0; k < 1500; k++) begin
            v = 16'h0000;
            for (int n = 0; n < 4; n++) begin
                if ($urandom_range(0, 1) == 1) v[4*n +: 4] = 4'($urandom_range(0, 15));
            end
            apply(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), v,
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
